// File: rtl/dx_diff.sv
// dx_diff: horizontal forward difference dx[p] = x[p+1] - x[p] over wide
// pixel beats, with zero at the right edge of every row.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             synchronous restart, same effect as rst
//   in_valid/ready  input beat handshake; in_data lane i at [i*DW +: DW]
//   out_valid       one-cycle strobe with out_data / out_addr
//   frame_done      pulses with the final beat of the last row
module dx_diff #(
    parameter int PORT_SIZE = 16,
    parameter int DW        = 16,
    parameter int COL_WIDTH = 4,
    parameter int ROW_NUM   = 48,
    parameter int AW        = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PORT_SIZE*DW-1:0] in_data,
    output logic                    out_valid,
    output logic [PORT_SIZE*DW-1:0] out_data,
    output logic [AW-1:0]           out_addr,
    output logic                    frame_done
);

    localparam int CW    = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
    localparam int RW    = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int NBEAT = ROW_NUM * COL_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FLUSH
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [PORT_SIZE*DW-1:0] h_q;
    logic [CW-1:0]           col_q;
    logic [RW-1:0]           row_q;
    logic [AW-1:0]           cnt_q;

    logic                    accept;
    logic                    load;
    logic                    emit;
    logic                    col_last;
    logic                    row_last;
    logic                    cnt_last;
    logic [PORT_SIZE*DW-1:0] diff_d;

    assign in_ready = (state_q != FLUSH);
    assign accept   = in_valid & in_ready;
    assign col_last = (col_q == CW'(COL_WIDTH - 1));
    assign row_last = (row_q == RW'(ROW_NUM - 1));
    assign cnt_last = (cnt_q == AW'(NBEAT - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        emit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = col_last ? FLUSH : HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    load    = 1'b1;
                    emit    = 1'b1;
                    state_d = col_last ? FLUSH : HOLD;
                end
            end
            FLUSH: begin
                emit    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The top lane borrows lane 0 of the incoming beat; at the row end
    // there is no right neighbour, so it is forced to zero.
    always_comb begin
        diff_d = '0;
        for (int i = 0; i < PORT_SIZE - 1; i++) begin
            diff_d[i*DW +: DW] = h_q[(i+1)*DW +: DW] - h_q[i*DW +: DW];
        end
        if (state_q != FLUSH) begin
            diff_d[(PORT_SIZE-1)*DW +: DW] =
                in_data[0 +: DW] - h_q[(PORT_SIZE-1)*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q    <= IDLE;
            h_q        <= '0;
            col_q      <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_valid  <= emit;
            frame_done <= 1'b0;
            if (load) begin
                h_q   <= in_data;
                col_q <= col_last ? '0 : col_q + 1'b1;
            end
            if (emit) begin
                out_data <= diff_d;
                out_addr <= cnt_q;
                cnt_q    <= cnt_last ? '0 : cnt_q + 1'b1;
            end
            if (state_q == FLUSH) begin
                col_q      <= '0;
                row_q      <= row_last ? '0 : row_q + 1'b1;
                frame_done <= row_last;
            end
        end
    end

endmodule

// File: tb/tb_dx_diff.sv
// tb_dx_diff: randomized and directed stimulus for dx_diff, checked
// against a row-level forward-difference model.
module tb_dx_diff;

    localparam int PS   = 16;
    localparam int DW   = 16;
    localparam int COLW = 4;
    localparam int ROWN = 48;
    localparam int AW   = 8;
    localparam int BW   = PS * DW;
    localparam int RPX  = PS * COLW;
    localparam int NB   = ROWN * COLW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic          out_valid;
    logic [BW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          frame_done;

    dx_diff #(
        .PORT_SIZE(PS),
        .DW(DW),
        .COL_WIDTH(COLW),
        .ROW_NUM(ROWN),
        .AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_addr(out_addr),
        .frame_done(frame_done)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [BW-1:0] d;
        logic [AW-1:0] a;
        logic          fd;
    } ob_t;

    ob_t obs[$];
    ob_t expq[$];
    int  fd_cnt = 0;
    int  n_chk  = 0;
    int  n_pass = 0;

    logic [DW-1:0] rowpix[RPX];
    int            mcol  = 0;
    int            maddr = 0;

    always @(negedge clk) begin
        if (out_valid) obs.push_back('{out_data, out_addr, frame_done});
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [BW-1:0] got,
                       input logic [BW-1:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Output beat c of the current row: dx over its pixels, zero past
    // the right edge of the row.
    task automatic push_beat(input int c);
        logic [BW-1:0] d;
        int p;
        d = '0;
        for (int l = 0; l < PS; l++) begin
            p = c * PS + l;
            if (p != RPX - 1)
                d[l*DW +: DW] = rowpix[p+1] - rowpix[p];
        end
        expq.push_back('{d, AW'(maddr), maddr == NB - 1});
        maddr = (maddr + 1) % NB;
    endtask

    // A beat's difference exists once its right neighbour is known.
    task automatic model_accept(input logic [BW-1:0] b);
        for (int l = 0; l < PS; l++) rowpix[mcol*PS + l] = b[l*DW +: DW];
        if (mcol > 0) push_beat(mcol - 1);
        if (mcol == COLW - 1) begin
            push_beat(mcol);
            mcol = 0;
        end else begin
            mcol++;
        end
    endtask

    task automatic send(input logic [BW-1:0] b, input int gap);
        int t;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        t = 0;
        while (!in_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (t == 10) chk("ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        model_accept(b);
        in_valid = 1'b0;
    endtask

    task automatic do_clr(input logic with_valid, input logic [BW-1:0] b);
        clr      = 1'b1;
        in_valid = with_valid;
        in_data  = b;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        mcol     = 0;
        maddr    = 0;
        chk("clr_valid", out_valid, 0);
        chk("clr_data", out_data, 0);
        chk("clr_addr", out_addr, 0);
        chk("clr_ready", in_ready, 1);
    endtask

    task automatic compare(input string tag);
        int n;
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, obs.size(), expq.size());
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, obs[i].d, expq[i].d);
            chk({tag, "_addr"}, obs[i].a, expq[i].a);
            chk({tag, "_fd"}, obs[i].fd, expq[i].fd);
        end
        obs.delete();
        expq.delete();
    endtask

    function automatic logic [BW-1:0] rnd_beat();
        logic [BW-1:0] b;
        for (int l = 0; l < PS; l++) b[l*DW +: DW] = DW'($urandom);
        return b;
    endfunction

    initial begin
        logic [BW-1:0] b;
        logic [BW-1:0] ones;
        logic [BW-1:0] carry;

        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // ramp row: pixel p = p
        for (int c = 0; c < COLW; c++) begin
            for (int l = 0; l < PS; l++) b[l*DW +: DW] = DW'(c * PS + l);
            send(b, 0);
        end
        chk("ramp_rdy_lo", in_ready, 0);
        @(negedge clk);
        chk("ramp_rdy_hi", in_ready, 1);
        repeat (3) @(negedge clk);
        for (int l = 0; l < PS; l++) ones[l*DW +: DW] = 16'h0001;
        if (obs.size() >= 4) begin
            chk("ramp_b0", obs[0].d, ones);
            chk("ramp_b3_l15", obs[3].d[BW-1 -: DW], 0);
            chk("ramp_b3_l0", obs[3].d[DW-1:0], 1);
            chk("ramp_b3_addr", obs[3].a, 3);
        end else begin
            chk("ramp_nout", obs.size(), 4);
        end
        compare("ramp");

        // carry across beat boundary
        for (int l = 0; l < PS; l++) b[l*DW +: DW] = 16'h0005;
        send(b, 0);
        b = rnd_beat();
        b[DW-1:0] = 16'h0009;
        send(b, 0);
        send(rnd_beat(), 0);
        send(rnd_beat(), 0);
        repeat (3) @(negedge clk);
        carry = '0;
        carry[BW-1 -: DW] = 16'h0004;
        if (obs.size() >= 1) begin
            chk("carry_b0", obs[0].d, carry);
            chk("carry_addr", obs[0].a, 4);
        end else begin
            chk("carry_nout", obs.size(), 1);
        end
        compare("carry");

        // wrap-around arithmetic
        b = '0;
        b[0*DW +: DW] = 16'h8000;
        b[1*DW +: DW] = 16'h7FFF;
        b[2*DW +: DW] = 16'h7FFF;
        b[3*DW +: DW] = 16'h8000;
        b[4*DW +: DW] = 16'h0001;
        b[5*DW +: DW] = 16'h8000;
        send(b, 0);
        for (int c = 1; c < COLW; c++) send(rnd_beat(), 0);
        repeat (3) @(negedge clk);
        if (obs.size() >= 1) begin
            chk("wrap_neg", obs[0].d[0*DW +: DW], 16'hFFFF);
            chk("wrap_pos", obs[0].d[2*DW +: DW], 16'h0001);
            chk("wrap_min", obs[0].d[4*DW +: DW], 16'h7FFF);
        end else begin
            chk("wrap_nout", obs.size(), 1);
        end
        compare("wrap");

        // en pattern: 8 on, 2 off, 5 on, 2 off, on
        for (int i = 0; i < 4 * COLW; i++)
            send(rnd_beat(), (i == 8 || i == 13) ? 2 : 0);
        compare("stall");

        // random gaps
        for (int i = 0; i < 10 * COLW; i++)
            send(rnd_beat(), $urandom_range(0, 3));
        compare("rand");

        // full frame from a clean start, then one more row
        do_clr(1'b0, '0);
        fd_cnt = 0;
        for (int i = 0; i < NB; i++)
            send(rnd_beat(), ($urandom_range(0, 7) == 0) ? 1 : 0);
        repeat (3) @(negedge clk);
        chk("frame_fd_cnt", fd_cnt, 1);
        if (obs.size() == NB) begin
            chk("frame_last_fd", obs[NB-1].fd, 1);
            chk("frame_last_addr", obs[NB-1].a, NB - 1);
        end else begin
            chk("frame_nout", obs.size(), NB);
        end
        compare("frame");
        for (int c = 0; c < COLW; c++) send(rnd_beat(), 0);
        repeat (3) @(negedge clk);
        if (obs.size() >= 1) chk("wrap_addr0", obs[0].a, 0);
        else chk("wrap_nout0", obs.size(), 1);
        compare("after_frame");

        // mid-row clr, with a beat presented during clr
        send(rnd_beat(), 0);
        send(rnd_beat(), 0);
        compare("abort");
        do_clr(1'b1, rnd_beat());
        for (int c = 0; c < COLW; c++) send(rnd_beat(), $urandom_range(0, 1));
        repeat (3) @(negedge clk);
        if (obs.size() >= 1) chk("restart_addr", obs[0].a, 0);
        else chk("restart_nout", obs.size(), 1);
        compare("restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
